// File: rtl/ssd_value_scheduler.sv
// ssd_value_scheduler
//   Time-shares one two-digit Pmod SSD between par_num_src 8-bit value
//   sources. Each valid source is shown for par_dwell_cycles clocks, and the
//   sources rotate round-robin. All outputs are registered and feed the
//   i_value0/i_value1 nibble inputs of one_pmod_ssd_display.
//
//   Build option: define SSD_SCHED_PRI_OVERRIDE_EN to build the priority
//   override (PRI state, i_pri_req/i_pri_value, o_pri_active). Without it the
//   override inputs are ignored, o_pri_active stays 0 and rotation is never
//   preempted.
module ssd_value_scheduler #(
    parameter int par_num_src      = 4,         // 2..8
    parameter int par_dwell_cycles = 20000000   // clocks per slot, >= 2
) (
    input  logic                     i_clk_20mhz,
    input  logic                     i_rst_20mhz,
    input  logic [par_num_src-1:0]   i_req_valid,
    input  logic [8*par_num_src-1:0] i_req_value,
    input  logic                     i_hold,
    input  logic                     i_pri_req,
    input  logic [7:0]               i_pri_value,
    output logic [3:0]               o_value0,
    output logic [3:0]               o_value1,
    output logic [2:0]               o_src_idx,
    output logic [par_num_src-1:0]   o_grant,
    output logic                     o_pri_active,
    output logic                     o_dwell_done
);

    localparam int                 CNT_W   = $clog2(par_dwell_cycles);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(par_dwell_cycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_PRI
    } state_t;

    // Result of a round-robin search over the valid vector.
    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;          // granted / saved source index
    logic [CNT_W-1:0] cnt_q, cnt_d;          // dwell counter
    logic [7:0]       value_q, value_d;
    logic [par_num_src-1:0] grant_q, grant_d;
    logic             pri_active_q, pri_active_d;
    logic             done_q, done_d;

    // Requests widened to the full 8-source range so a 3-bit index always
    // addresses a real bit; unused sources read as invalid.
    logic [7:0]       valid_ext;
    logic [7:0]       value_tab [8];
    logic [7:0]       grant_oh;
    pick_t            rot_pick;              // search from idx+1, idx last
    pick_t            first_pick;            // search from idx inclusive

    // Searches par_num_src candidates starting at start (+1 when skip_start),
    // wrapping modulo par_num_src; the earliest valid candidate wins.
    function automatic pick_t find_valid(input logic [7:0] valid,
                                         input logic [2:0] start,
                                         input logic       skip_start);
        pick_t pick;
        int    cand;
        pick = '0;
        for (int k = par_num_src - 1; k >= 0; k--) begin
            cand = int'(start) + int'(skip_start) + k;
            if (cand >= par_num_src) begin
                cand = cand - par_num_src;
            end
            if (valid[cand[2:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[2:0];
            end
        end
        return pick;
    endfunction

    // Widen the request bus into fixed 8-entry tables.
    always_comb begin
        valid_ext                    = '0;
        valid_ext[par_num_src-1:0]   = i_req_valid;
        for (int k = 0; k < 8; k++) begin
            value_tab[k] = 8'h00;
        end
        for (int k = 0; k < par_num_src; k++) begin
            value_tab[k] = i_req_value[8*k +: 8];
        end
    end

    assign rot_pick   = find_valid(valid_ext, idx_q, 1'b1);
    assign first_pick = find_valid(valid_ext, idx_q, 1'b0);

`ifndef SSD_SCHED_PRI_OVERRIDE_EN
    // Override inputs exist on the port list but have no function here.
    logic unused_pri;
    assign unused_pri = ^{i_pri_req, i_pri_value};
`endif

    // Next-state, counter and registered-output logic.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        value_d      = 8'h00;
        grant_d      = '0;
        grant_oh     = 8'h00;
        pri_active_d = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
`ifdef SSD_SCHED_PRI_OVERRIDE_EN
                if (i_pri_req) begin
                    state_d = ST_PRI;
                end else
`endif
                if (first_pick.found) begin
                    state_d = ST_SHOW;
                    idx_d   = first_pick.idx;
                end
            end

            ST_SHOW: begin
`ifdef SSD_SCHED_PRI_OVERRIDE_EN
                // Preemption wins over both valid-drop and expiry; the index
                // is kept in idx_q for the resume.
                if (i_pri_req) begin
                    state_d = ST_PRI;
                end else
`endif
                if (!valid_ext[idx_q]) begin
                    cnt_d = '0;
                    if (rot_pick.found) begin
                        idx_d = rot_pick.idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!i_hold) begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                        idx_d  = rot_pick.idx;   // current source is last candidate
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

`ifdef SSD_SCHED_PRI_OVERRIDE_EN
            ST_PRI: begin
                if (!i_pri_req) begin
                    cnt_d   = '0;
                    state_d = ST_SHOW;
                    if (!valid_ext[idx_q]) begin
                        if (rot_pick.found) begin
                            idx_d = rot_pick.idx;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are computed from the next state so they register with it.
        if (state_d == ST_SHOW) begin
            grant_oh = 8'h01 << idx_d;
            grant_d  = grant_oh[par_num_src-1:0];
            value_d  = value_tab[idx_d];
        end else if (state_d == ST_PRI) begin
            value_d      = i_pri_value;
            pri_active_d = 1'b1;
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge i_clk_20mhz) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (i_rst_20mhz) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            value_q      <= 8'h00;
            grant_q      <= '0;
            pri_active_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            value_q      <= value_d;
            grant_q      <= grant_d;
            pri_active_q <= pri_active_d;
            done_q       <= done_d;
        end
    end

    assign o_value0     = value_q[3:0];
    assign o_value1     = value_q[7:4];
    assign o_src_idx    = idx_q;
    assign o_grant      = grant_q;
    assign o_pri_active = pri_active_q;
    assign o_dwell_done = done_q;

endmodule

// File: tb/tb_ssd_value_scheduler.sv
// tb_ssd_value_scheduler
//   Table-driven check of ssd_value_scheduler with 4 sources and a 4-clock
//   dwell, followed by hand-written corner-case sequences. Expectations for
//   the override follow SSD_SCHED_PRI_OVERRIDE_EN when it is defined.
module tb_ssd_value_scheduler;

    localparam logic [31:0] V1 = 32'h4399_213C;  // src3..src0
    localparam logic [31:0] V2 = 32'h4399_2110;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] vals;
        logic        hold;
        logic        pri;
        logic [7:0]  pri_val;
        logic [3:0]  eg;
        logic [2:0]  ei;
        logic [7:0]  ev;
        logic        ed;
        logic        ep;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_value;
    logic        hold;
    logic        pri_req;
    logic [7:0]  pri_value;
    logic [3:0]  value0, value1;
    logic [2:0]  src_idx;
    logic [3:0]  grant;
    logic        pri_active;
    logic        dwell_done;

    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vecs[$];

    ssd_value_scheduler #(
        .par_num_src     (4),
        .par_dwell_cycles(4)
    ) dut (
        .i_clk_20mhz (clk),
        .i_rst_20mhz (rst),
        .i_req_valid (req_valid),
        .i_req_value (req_value),
        .i_hold      (hold),
        .i_pri_req   (pri_req),
        .i_pri_value (pri_value),
        .o_value0    (value0),
        .o_value1    (value1),
        .o_src_idx   (src_idx),
        .o_grant     (grant),
        .o_pri_active(pri_active),
        .o_dwell_done(dwell_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] v, input logic [31:0] vals,
                       input logic h, input logic p, input logic [7:0] pv,
                       input logic [3:0] eg, input logic [2:0] ei, input logic [7:0] ev,
                       input logic ed, input logic ep);
        vec_t t;
        t.rst = r;  t.valid = v; t.vals = vals; t.hold = h; t.pri = p; t.pri_val = pv;
        t.eg = eg;  t.ei = ei;   t.ev = ev;     t.ed = ed;  t.ep = ep;
        vecs.push_back(t);
    endtask

    // Drive one cycle of inputs, let the edge take them, sample 1 ns later.
    task automatic apply(input logic r, input logic [3:0] v, input logic [31:0] vals,
                         input logic h, input logic p, input logic [7:0] pv);
        rst = r; req_valid = v; req_value = vals; hold = h; pri_req = p; pri_value = pv;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] eg, input logic [2:0] ei,
                         input logic [7:0] ev, input logic ed, input logic ep);
        n_vec++;
        if (grant !== eg || src_idx !== ei || {value1, value0} !== ev ||
            dwell_done !== ed || pri_active !== ep) begin
            n_miss++;
            $display("FAIL %s: got grant=%b idx=%0d value=%h done=%b pri=%b, want grant=%b idx=%0d value=%h done=%b pri=%b",
                     name, grant, src_idx, {value1, value0}, dwell_done, pri_active,
                     eg, ei, ev, ed, ep);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_value = V1; hold = 1'b0; pri_req = 1'b0; pri_value = 8'h00;

        // Reset, then a single source: slot repeats every 4 clocks.
        add(1, 4'b0000, V1, 0, 0, 8'h00, 4'b0000, 0, 8'h00, 0, 0);
        add(0, 4'b0000, V1, 0, 0, 8'h00, 4'b0000, 0, 8'h00, 0, 0);
        add(0, 4'b0001, V1, 0, 0, 8'h00, 4'b0001, 0, 8'h3C, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b0001, V1, 0, 0, 8'h00, 4'b0001, 0, 8'h3C, 0, 0);
        add(0, 4'b0001, V1, 0, 0, 8'h00, 4'b0001, 0, 8'h3C, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b0001, V1, 0, 0, 8'h00, 4'b0001, 0, 8'h3C, 0, 0);
        add(0, 4'b0001, V1, 0, 0, 8'h00, 4'b0001, 0, 8'h3C, 1, 0);
        // Three sources 0,1,3 rotate; value re-sampled each cycle.
        for (int i = 0; i < 3; i++) add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b0001, 0, 8'h10, 0, 0);
        add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b0010, 1, 8'h21, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b0010, 1, 8'h21, 0, 0);
        add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b1000, 3, 8'h43, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b1000, 3, 8'h43, 0, 0);
        add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b0001, 0, 8'h10, 1, 0);
        // Hold for 10 clocks mid-slot; slot still needs 4 non-hold clocks.
        add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b0001, 0, 8'h10, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 4'b1011, V2, 1, 0, 8'h00, 4'b0001, 0, 8'h10, 0, 0);
        for (int i = 0; i < 2; i++) add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b0001, 0, 8'h10, 0, 0);
        add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b0010, 1, 8'h21, 1, 0);
        add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b0010, 1, 8'h21, 0, 0);
        // Granted source drops mid-slot: next valid, counter cleared, no pulse.
        add(0, 4'b1001, V2, 0, 0, 8'h00, 4'b1000, 3, 8'h43, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b1001, V2, 0, 0, 8'h00, 4'b1000, 3, 8'h43, 0, 0);
        add(0, 4'b1001, V2, 0, 0, 8'h00, 4'b0001, 0, 8'h10, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b1001, V2, 0, 0, 8'h00, 4'b0001, 0, 8'h10, 0, 0);
        // Drop on the expiry cycle: rotation without a pulse.
        add(0, 4'b1000, V2, 0, 0, 8'h00, 4'b1000, 3, 8'h43, 0, 0);
        // Nothing valid: IDLE, then search from saved index 3 inclusive.
        add(0, 4'b0000, V2, 0, 0, 8'h00, 4'b0000, 3, 8'h00, 0, 0);
        add(0, 4'b0011, V2, 0, 0, 8'h00, 4'b0001, 0, 8'h10, 0, 0);
        add(0, 4'b0011, V2, 0, 0, 8'h00, 4'b0001, 0, 8'h10, 0, 0);
        add(0, 4'b0110, V2, 0, 0, 8'h00, 4'b0010, 1, 8'h21, 0, 0);
        add(0, 4'b0110, V2, 0, 0, 8'h00, 4'b0010, 1, 8'h21, 0, 0);
        // Reset mid-slot, then first grant searches from index 0.
        add(1, 4'b0110, V2, 0, 0, 8'h00, 4'b0000, 0, 8'h00, 0, 0);
        add(0, 4'b1001, V2, 0, 0, 8'h00, 4'b0001, 0, 8'h10, 0, 0);
        // Reach idx 1, then raise override on its expiry cycle.
        for (int i = 0; i < 3; i++) add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b0001, 0, 8'h10, 0, 0);
        add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b0010, 1, 8'h21, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b0010, 1, 8'h21, 0, 0);
`ifdef SSD_SCHED_PRI_OVERRIDE_EN
        add(0, 4'b1011, V2, 0, 1, 8'hEE, 4'b0000, 1, 8'hEE, 0, 1);
        add(0, 4'b1011, V2, 0, 1, 8'h5A, 4'b0000, 1, 8'h5A, 0, 1);
        add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b0010, 1, 8'h21, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b0010, 1, 8'h21, 0, 0);
        add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b1000, 3, 8'h43, 1, 0);
`else
        add(0, 4'b1011, V2, 0, 1, 8'hEE, 4'b1000, 3, 8'h43, 1, 0);
        add(0, 4'b1011, V2, 0, 1, 8'h5A, 4'b1000, 3, 8'h43, 0, 0);
        add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b1000, 3, 8'h43, 0, 0);
        add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b1000, 3, 8'h43, 0, 0);
        add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b0001, 0, 8'h10, 1, 0);
        add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b0001, 0, 8'h10, 0, 0);
        add(0, 4'b1011, V2, 0, 0, 8'h00, 4'b0001, 0, 8'h10, 0, 0);
`endif

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].valid, vecs[i].vals, vecs[i].hold, vecs[i].pri, vecs[i].pri_val);
            check($sformatf("vec%0d", i), vecs[i].eg, vecs[i].ei, vecs[i].ev, vecs[i].ed, vecs[i].ep);
        end

        // Hold exactly on the expiry cycle suppresses the pulse until release.
        apply(1, 4'b0000, V2, 0, 0, 8'h00);
        check("hs_reset", 4'b0000, 0, 8'h00, 0, 0);
        apply(0, 4'b0101, V2, 0, 0, 8'h00);
        check("hs_grant", 4'b0001, 0, 8'h10, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(0, 4'b0101, V2, 0, 0, 8'h00);
            check($sformatf("hs_count%0d", i), 4'b0001, 0, 8'h10, 0, 0);
        end
        for (int i = 0; i < 2; i++) begin
            apply(0, 4'b0101, V2, 1, 0, 8'h00);
            check($sformatf("hs_hold_expiry%0d", i), 4'b0001, 0, 8'h10, 0, 0);
        end
        apply(0, 4'b0101, V2, 0, 0, 8'h00);
        check("hs_release_expiry", 4'b0100, 2, 8'h99, 1, 0);
        // Hold does not block valid-drop rotation.
        apply(0, 4'b0001, V2, 1, 0, 8'h00);
        check("hs_drop_under_hold", 4'b0001, 0, 8'h10, 0, 0);
        // Hold does not block preemption.
        apply(0, 4'b0001, V2, 1, 1, 8'h77);
`ifdef SSD_SCHED_PRI_OVERRIDE_EN
        check("hs_pri_under_hold", 4'b0000, 0, 8'h77, 0, 1);
`else
        check("hs_pri_ignored", 4'b0001, 0, 8'h10, 0, 0);
`endif
        // Release with nothing valid lands in IDLE.
        apply(0, 4'b0000, V2, 0, 0, 8'h00);
        check("hs_idle_empty", 4'b0000, 0, 8'h00, 0, 0);
        // Override from IDLE, then resume past an invalid saved index.
        apply(0, 4'b0000, V2, 0, 1, 8'h12);
`ifdef SSD_SCHED_PRI_OVERRIDE_EN
        check("hs_pri_from_idle", 4'b0000, 0, 8'h12, 0, 1);
        apply(0, 4'b0100, V2, 0, 1, 8'h12);
        check("hs_pri_stay", 4'b0000, 0, 8'h12, 0, 1);
`else
        check("hs_idle_pri_ignored", 4'b0000, 0, 8'h00, 0, 0);
        apply(0, 4'b0100, V2, 0, 1, 8'h12);
        check("hs_idle_grant", 4'b0100, 2, 8'h99, 0, 0);
`endif
        apply(0, 4'b0100, V2, 0, 0, 8'h00);
        check("hs_resume_next", 4'b0100, 2, 8'h99, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
